// File: rtl/led_fade_engine.sv
// Eight-channel exponential fade sequencer feeding the PWM channel values.
// Steps are paced by ramp wraps through a prescaler and applied one channel per cycle.
module led_fade_engine #(
    parameter logic [7:0] RESET_PRESCALE = 8'd1,
    parameter logic [2:0] RESET_SHIFT    = 3'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ramp_wrap,
    input  logic        wen,
    input  logic [4:0]  addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic [63:0] pwm_val,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t     state;
    logic [7:0] target  [8];
    logic [7:0] current [8];
    logic [7:0] prescale;
    logic [2:0] shift;
    logic       enable;
    logic [7:0] cnt;
    logic       step_req;
    logic       pending;
    logic [2:0] idx;
    logic [7:0] cnt_max;

    assign cnt_max = (prescale == 8'd0) ? 8'd0 : prescale - 8'd1;

    // Move cur toward tgt by (diff >> sh), at least 1; delta <= diff so no overshoot.
    function automatic logic [7:0] step_val(input logic [7:0] cur, input logic [7:0] tgt,
                                            input logic [2:0] sh);
        logic [7:0] diff;
        logic [7:0] delta;
        diff  = (tgt >= cur) ? tgt - cur : cur - tgt;
        delta = diff >> sh;
        if (delta == 8'd0 && diff != 8'd0) delta = 8'd1;
        return (tgt >= cur) ? cur + delta : cur - delta;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                target[i]  <= 8'd0;
                current[i] <= 8'd0;
            end
            prescale <= RESET_PRESCALE;
            shift    <= RESET_SHIFT;
            enable   <= 1'b0;
            cnt      <= 8'd0;
            step_req <= 1'b0;
            pending  <= 1'b0;
            idx      <= 3'd0;
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done     <= 1'b0;
            step_req <= 1'b0;
            if (enable && ramp_wrap) begin
                if (cnt == cnt_max) begin
                    cnt      <= 8'd0;
                    step_req <= 1'b1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (step_req || pending) begin
                        state   <= SCAN;
                        idx     <= 3'd0;
                        pending <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                SCAN: begin
                    current[idx] <= step_val(current[idx], target[idx], shift);
                    idx          <= idx + 3'd1;
                    if (step_req) pending <= 1'b1;
                    if (idx == 3'd7) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Register writes come last so disable/snap override the scan and prescaler above.
            if (wen) begin
                if (addr < 5'h08) begin
                    target[addr[2:0]] <= wdata;
                end else if (addr == 5'h10) begin
                    prescale <= wdata;
                end else if (addr == 5'h11) begin
                    shift <= wdata[2:0];
                end else if (addr == 5'h12) begin
                    enable <= wdata[0];
                    if (!wdata[0]) begin
                        cnt      <= 8'd0;
                        pending  <= 1'b0;
                        step_req <= 1'b0;
                    end
                    if (wdata[1]) begin
                        for (int i = 0; i < 8; i++) current[i] <= target[i];
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b0;
                        pending  <= 1'b0;
                        step_req <= 1'b0;
                        cnt      <= 8'd0;
                    end
                end
            end
        end
    end

    always_comb begin
        rdata = 8'd0;
        if (addr < 5'h08)       rdata = target[addr[2:0]];
        else if (addr < 5'h10)  rdata = current[addr[2:0]];
        else if (addr == 5'h10) rdata = prescale;
        else if (addr == 5'h11) rdata = {5'd0, shift};
        else if (addr == 5'h12) rdata = {7'd0, enable};
    end

    always_comb begin
        pwm_val = '0;
        for (int i = 0; i < 8; i++) pwm_val[8*i +: 8] = current[i];
    end

endmodule

// File: tb/tb_led_fade_engine.sv
// Directed bench for led_fade_engine: reset, fades, prescale, pending, target race, snap.
module tb_led_fade_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ramp_wrap;
    logic        wen;
    logic [4:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [63:0] pwm_val;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    led_fade_engine dut (
        .clk(clk), .rst_n(rst_n), .ramp_wrap(ramp_wrap), .wen(wen), .addr(addr),
        .wdata(wdata), .rdata(rdata), .pwm_val(pwm_val), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        wen = 1'b1; addr = a; wdata = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    // One wrap pulse, then 30 cycles counting busy/done; optional second wrap at loop index extra.
    task automatic run_scan(input int extra, output int bc, output int dc);
        bc = 0; dc = 0;
        ramp_wrap = 1'b1;
        tick();
        for (int i = 0; i < 30; i++) begin
            ramp_wrap = (i == extra);
            tick();
            if (busy) bc++;
            if (done) dc++;
        end
        ramp_wrap = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        int bc, dc;

        rst_n = 1'b0; ramp_wrap = 1'b0; wen = 1'b1; addr = 5'h00; wdata = 8'hFF;
        repeat (2) tick();
        rst_n = 1'b1; wen = 1'b0;
        chk("rst_pwm", pwm_val, 64'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rd(5'h00, d); chk("rst_target0", d, 8'h00);
        rd(5'h10, d); chk("rst_prescale", d, 8'h01);
        rd(5'h11, d); chk("rst_shift", d, 8'h03);

        // Exponential fade of ch0 to 0xFF with shift 2
        wr(5'h00, 8'hFF); wr(5'h11, 8'h02); wr(5'h12, 8'h01);
        run_scan(-1, bc, dc);
        chk("fade1_busy_cycles", bc, 8);
        chk("fade1_done_pulses", dc, 1);
        chk("fade1_ch0", pwm_val[7:0], 8'd63);
        run_scan(-1, bc, dc);
        chk("fade2_ch0", pwm_val[7:0], 8'd111);
        for (int s = 0; s < 30; s++) run_scan(-1, bc, dc);
        chk("fade_final_ch0", pwm_val[7:0], 8'hFF);
        rd(5'h08, d); chk("fade_read_cur0", d, 8'hFF);

        // Shift keeps only 3 bits; shift 0 jumps in one step
        wr(5'h11, 8'hF8);
        rd(5'h11, d); chk("shift_mask", d, 8'h00);
        wr(5'h01, 8'h02);
        run_scan(-1, bc, dc);
        chk("snap_step_ch1", pwm_val[15:8], 8'h02);

        // Minimum step of 1 downward, then hold
        wr(5'h11, 8'h07); wr(5'h01, 8'h00);
        run_scan(-1, bc, dc); chk("min_step1", pwm_val[15:8], 8'h01);
        run_scan(-1, bc, dc); chk("min_step2", pwm_val[15:8], 8'h00);
        run_scan(-1, bc, dc); chk("min_hold", pwm_val[15:8], 8'h00);
        chk("min_ch0_hold", pwm_val[7:0], 8'hFF);

        // Prescale 3: only every third wrap steps; prescale 0 acts as 1
        wr(5'h10, 8'h03);
        rd(5'h10, d); chk("prescale_rd", d, 8'h03);
        run_scan(-1, bc, dc); chk("ps3_wrap1", bc, 0);
        run_scan(-1, bc, dc); chk("ps3_wrap2", bc, 0);
        run_scan(-1, bc, dc); chk("ps3_wrap3", bc, 8);
        wr(5'h10, 8'h00);
        run_scan(-1, bc, dc); chk("ps0_wrap", bc, 8);

        // Target write on the edge ch3 is updated
        wr(5'h11, 8'h00); wr(5'h03, 8'h40);
        ramp_wrap = 1'b1; tick(); ramp_wrap = 1'b0;
        repeat (4) tick();
        wen = 1'b1; addr = 5'h03; wdata = 8'h80;
        tick();
        wen = 1'b0;
        chk("race_ch3_old", pwm_val[31:24], 8'h40);
        rd(5'h03, d); chk("race_target3", d, 8'h80);
        repeat (10) tick();
        run_scan(-1, bc, dc);
        chk("race_ch3_new", pwm_val[31:24], 8'h80);

        // Wrap mid-scan queues a second scan back to back
        run_scan(2, bc, dc);
        chk("pend_busy_cycles", bc, 16);
        chk("pend_done_pulses", dc, 2);

        // Current registers are read-only; unmapped reads 0
        wr(5'h0A, 8'h55);
        rd(5'h0A, d); chk("cur_ro", d, 8'h00);
        wr(5'h15, 8'h55);
        rd(5'h15, d); chk("unmapped_rd", d, 8'h00);

        // Snap during idx=4
        wr(5'h11, 8'h07);
        for (int k = 0; k < 8; k++) wr(5'(k), 8'(16 * k));
        ramp_wrap = 1'b1; tick(); ramp_wrap = 1'b0;
        repeat (5) tick();
        chk("snap_pre_busy", busy, 1'b1);
        wr(5'h12, 8'h03);
        chk("snap_pwm", pwm_val, 64'h7060504030201000);
        chk("snap_busy", busy, 1'b0);
        chk("snap_done", done, 1'b0);
        rd(5'h12, d); chk("snap_ctrl_rd", d, 8'h01);
        dc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) dc++;
        end
        chk("snap_no_done", dc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
